// File: rtl/floo_endsim_monitor.sv
// End-of-simulation monitor: sticky per-tile completion/error capture, NoC drain
// window and a run watchdog, all with registered outputs.
module floo_endsim_monitor #(
  parameter int unsigned NumTiles      = 4,
  parameter int unsigned NumBusy       = 4,
  parameter int unsigned DrainCycles   = 100,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clear_i,
  input  logic [NumTiles-1:0] tile_eoc_i,
  input  logic [NumTiles-1:0] tile_err_i,
  input  logic [NumBusy-1:0]  busy_i,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [NumTiles-1:0] done_mask_o,
  output logic [NumTiles-1:0] err_mask_o,
  output logic [CntWidth-1:0] cycles_o
);

  // A shift of 64 or more yields 0, so the subtraction wraps to all-ones.
  localparam longint unsigned CntMax = (64'd1 << CntWidth) - 64'd1;

  if (NumTiles < 1 || NumBusy < 1) begin : g_bad_widths
    $error("floo_endsim_monitor: NumTiles and NumBusy must be at least 1");
  end
  if (longint'(TimeoutCycles) > CntMax || longint'(DrainCycles) > CntMax) begin : g_bad_counts
    $error("floo_endsim_monitor: TimeoutCycles and DrainCycles must fit in CntWidth bits");
  end

  localparam logic [CntWidth-1:0] DrainLast   = CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, TIMEOUT} state_e;

  state_e              state_q;
  logic [CntWidth-1:0] cycles_q;
  logic [CntWidth-1:0] idle_q;
  logic [NumTiles-1:0] done_mask_q;
  logic [NumTiles-1:0] err_mask_q;
  logic                done_q;
  logic                pass_q;
  logic                timeout_q;

  logic [NumTiles-1:0] next_mask;
  logic [NumTiles-1:0] next_err;
  logic [CntWidth-1:0] cycles_inc;
  logic                all_done;
  logic                any_busy;
  logic                wd_hit;

  // Error bits are loaded only for tiles completing this cycle, so they never change later.
  always_comb begin
    next_mask  = done_mask_q | tile_eoc_i;
    next_err   = err_mask_q | (tile_eoc_i & ~done_mask_q & tile_err_i);
    all_done   = &next_mask;
    any_busy   = |busy_i;
    wd_hit     = (TimeoutCycles != 0) && (cycles_q >= TimeoutLast);
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      idle_q      <= '0;
      done_mask_q <= '0;
      err_mask_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      idle_q      <= '0;
      done_mask_q <= '0;
      err_mask_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q  <= RUN;
            cycles_q <= '0;
          end
        end
        RUN: begin
          cycles_q    <= cycles_inc;
          done_mask_q <= next_mask;
          err_mask_q  <= next_err;
          // Only a completion straight to DONE beats the watchdog; entering DRAIN does not.
          if (all_done && DrainCycles == 0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (next_err == '0);
          end else if (wd_hit) begin
            state_q   <= TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (all_done) begin
            state_q <= DRAIN;
            idle_q  <= '0;
          end
        end
        DRAIN: begin
          cycles_q    <= cycles_inc;
          done_mask_q <= next_mask;
          err_mask_q  <= next_err;
          idle_q      <= any_busy ? '0 : idle_q + 1'b1;
          if (!any_busy && idle_q == DrainLast) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (next_err == '0);
          end else if (wd_hit) begin
            state_q   <= TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DONE, TIMEOUT: begin
          state_q <= state_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign done_mask_o = done_mask_q;
  assign err_mask_o  = err_mask_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_floo_endsim_monitor.sv
// Bench for floo_endsim_monitor: a vector table on the main instance plus directed
// sequences on three instances (drain 8 / timeout 200, drain 0 / no timeout, drain 0 / timeout 20).
module tb_floo_endsim_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic [3:0] eoc;
  logic [3:0] err;
  logic [1:0] busy;

  logic        a_done, a_pass, a_timeout;
  logic [3:0]  a_dmask, a_emask;
  logic [31:0] a_cycles;
  logic        b_done, b_pass, b_timeout;
  logic [3:0]  b_dmask, b_emask;
  logic [31:0] b_cycles;
  logic        c_done, c_pass, c_timeout;
  logic [3:0]  c_dmask, c_emask;
  logic [31:0] c_cycles;

  int cmp_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic        en;
    logic        clear;
    logic [3:0]  eoc;
    logic [3:0]  err;
    logic [1:0]  busy;
    logic        done;
    logic        pass;
    logic        tmo;
    logic [3:0]  dmask;
    logic [3:0]  emask;
    logic [31:0] cycles;
  } vec_t;

  vec_t vecs [20];

  floo_endsim_monitor #(.NumTiles(4), .NumBusy(2), .DrainCycles(8), .TimeoutCycles(200), .CntWidth(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .tile_eoc_i(eoc), .tile_err_i(err),
    .busy_i(busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_timeout),
    .done_mask_o(a_dmask), .err_mask_o(a_emask), .cycles_o(a_cycles));

  floo_endsim_monitor #(.NumTiles(4), .NumBusy(2), .DrainCycles(0), .TimeoutCycles(0), .CntWidth(32)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .tile_eoc_i(eoc), .tile_err_i(err),
    .busy_i(busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_timeout),
    .done_mask_o(b_dmask), .err_mask_o(b_emask), .cycles_o(b_cycles));

  floo_endsim_monitor #(.NumTiles(4), .NumBusy(2), .DrainCycles(0), .TimeoutCycles(20), .CntWidth(32)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .tile_eoc_i(eoc), .tile_err_i(err),
    .busy_i(busy), .done_o(c_done), .pass_o(c_pass), .timeout_o(c_timeout),
    .done_mask_o(c_dmask), .err_mask_o(c_emask), .cycles_o(c_cycles));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic c, input logic [3:0] eo,
                               input logic [3:0] er, input logic [1:0] b);
    en    = e;
    clear = c;
    eoc   = eo;
    err   = er;
    busy  = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStep();
    applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
  endtask

  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    //          en clr eoc   err   busy   done pass tmo dmask emask cycles
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'h4, 4'h4, 2'b00, 1'b0, 1'b0, 1'b0, 4'h4, 4'h4, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 4'h4, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h4, 4'h4, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 4'h3, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h7, 4'h4, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 4'h7, 4'h4, 32'd4};
    vecs[6]  = '{1'b0, 1'b0, 4'h8, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd5};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd6};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd7};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd8};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd9};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd10};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd11};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd12};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd13};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 4'h4, 32'd14};
    vecs[16] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 4'hF, 4'h4, 32'd15};
    vecs[17] = '{1'b1, 1'b0, 4'hF, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 4'hF, 4'h4, 32'd15};
    vecs[18] = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'd0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    #3;
    checkOutput("reset_done", a_done, 0);
    checkOutput("reset_pass", a_pass, 0);
    checkOutput("reset_timeout", a_timeout, 0);
    checkOutput("reset_dmask", a_dmask, 0);
    checkOutput("reset_emask", a_emask, 0);
    checkOutput("reset_cycles", a_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table: error capture with a drain restart, terminal hold and clear.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].en, vecs[i].clear, vecs[i].eoc, vecs[i].err, vecs[i].busy);
      step();
      checkOutput($sformatf("vec%0d_done", i), a_done, vecs[i].done);
      checkOutput($sformatf("vec%0d_pass", i), a_pass, vecs[i].pass);
      checkOutput($sformatf("vec%0d_timeout", i), a_timeout, vecs[i].tmo);
      checkOutput($sformatf("vec%0d_dmask", i), a_dmask, vecs[i].dmask);
      checkOutput($sformatf("vec%0d_emask", i), a_emask, vecs[i].emask);
      checkOutput($sformatf("vec%0d_cycles", i), a_cycles, vecs[i].cycles);
    end

    // Basic completion: tiles finish at run cycles 10, 12, 12, 20.
    clearStep();
    startRun();
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 10) ? 4'h1 : (k == 12) ? 4'h6 : (k == 20) ? 4'h8 : 4'h0,
                    4'h0, 2'b00);
      step();
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    checkOutput("basic_done_early", a_done, 0);
    n = 0;
    while (!a_done && n < 50) begin step(); n++; end
    checkOutput("basic_extra_edges", n, 8);
    checkOutput("basic_pass", a_pass, 1);
    checkOutput("basic_dmask", a_dmask, 4'hF);
    checkOutput("basic_cycles", a_cycles, 29);

    // Drain restart: busy pulse at idle count 6.
    clearStep();
    startRun();
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 5) ? 4'hF : 4'h0, 4'h0, 2'b00);
      step();
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    for (int k = 0; k < 6; k++) step();
    checkOutput("restart_done_early", a_done, 0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b10);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    n = 0;
    while (!a_done && n < 50) begin step(); n++; end
    checkOutput("restart_idle_edges", n, 8);
    checkOutput("restart_pass", a_pass, 1);

    // Timeout: tile 3 never finishes.
    clearStep();
    startRun();
    applyStimulus(1'b0, 1'b0, 4'h7, 4'h0, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    n = 0;
    while (!a_timeout && n < 300) begin step(); n++; end
    checkOutput("tmo_timeout", a_timeout, 1);
    checkOutput("tmo_done", a_done, 1);
    checkOutput("tmo_pass", a_pass, 0);
    checkOutput("tmo_dmask", a_dmask, 4'h7);
    checkOutput("tmo_cycles", a_cycles, 200);
    checkOutput("tmo_nowatchdog_b", b_timeout, 0);
    checkOutput("tmo_nodone_b", b_done, 0);
    applyStimulus(1'b1, 1'b0, 4'h8, 4'h8, 2'b11);
    for (int k = 0; k < 3; k++) step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    checkOutput("tmo_hold_dmask", a_dmask, 4'h7);
    checkOutput("tmo_hold_emask", a_emask, 4'h0);
    checkOutput("tmo_hold_cycles", a_cycles, 200);
    checkOutput("tmo_hold_timeout", a_timeout, 1);
    checkOutput("tmo_hold_pass", a_pass, 0);

    // Clear in DRAIN, then a fresh run completes.
    clearStep();
    startRun();
    applyStimulus(1'b0, 1'b0, 4'hF, 4'h2, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    for (int k = 0; k < 3; k++) step();
    checkOutput("clr_in_drain", a_done, 0);
    applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, 2'b00);
    step();
    checkOutput("clr_done", a_done, 0);
    checkOutput("clr_dmask", a_dmask, 0);
    checkOutput("clr_emask", a_emask, 0);
    checkOutput("clr_cycles", a_cycles, 0);
    startRun();
    applyStimulus(1'b0, 1'b0, 4'hF, 4'h0, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    n = 1;
    while (!a_done && n < 50) begin step(); n++; end
    checkOutput("clr_rerun_edges", n, 9);
    checkOutput("clr_rerun_pass", a_pass, 1);

    // Asynchronous reset between clock edges.
    clearStep();
    startRun();
    applyStimulus(1'b0, 1'b0, 4'h1, 4'h1, 2'b00);
    step();
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    step();
    step();
    checkOutput("arst_pre_dmask", a_dmask, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_dmask", a_dmask, 0);
    checkOutput("arst_emask", a_emask, 0);
    checkOutput("arst_cycles", a_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("arst_idle_cycles", a_cycles, 0);

    // No drain, no watchdog: completion in run cycle 3.
    clearStep();
    startRun();
    for (int k = 0; k <= 3; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 3) ? 4'hF : 4'h0, 4'h0, 2'b00);
      step();
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    checkOutput("edge_b_done", b_done, 1);
    checkOutput("edge_b_pass", b_pass, 1);
    checkOutput("edge_b_cycles", b_cycles, 4);
    checkOutput("edge_c_done", c_done, 1);
    checkOutput("edge_c_timeout", c_timeout, 0);
    checkOutput("edge_a_done", a_done, 0);

    // Completion on the watchdog's last cycle beats the timeout.
    clearStep();
    startRun();
    for (int k = 0; k <= 19; k++) begin
      applyStimulus(1'b0, 1'b0, (k == 0) ? 4'h7 : (k == 19) ? 4'h8 : 4'h0, 4'h0, 2'b00);
      step();
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
    checkOutput("race_c_done", c_done, 1);
    checkOutput("race_c_timeout", c_timeout, 0);
    checkOutput("race_c_pass", c_pass, 1);
    checkOutput("race_c_cycles", c_cycles, 20);

    // Same watchdog without a completion times out at 20.
    clearStep();
    startRun();
    for (int k = 0; k < 25; k++) step();
    checkOutput("wd20_c_timeout", c_timeout, 1);
    checkOutput("wd20_c_cycles", c_cycles, 20);
    checkOutput("wd20_c_pass", c_pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
